// File: rtl/clock_pkg.sv
// Shared definitions for the time-set mode controller.
//   mode_state_t    : edit FSM states, RUN plus one state per time field
//   btn_state_t     : per-button debounced level and one-cycle press pulse
//   DEFAULT_*       : default debounce / edit-timeout cycle counts at 50 MHz
//   field_sel()     : one-hot field select {year,month,day,hour,min,sec}
//   next_mode()     : advance order on a mode press
//   cnt_width()     : counter width for a cycle count, never below 1 bit
package clock_pkg;

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      E_SEC   = 3'd1,
      E_MIN   = 3'd2,
      E_HOUR  = 3'd3,
      E_DAY   = 3'd4,
      E_MONTH = 3'd5,
      E_YEAR  = 3'd6
   } mode_state_t;

   typedef struct packed {
      logic level;   // debounced, 1 = pressed
      logic press;   // one cycle on debounced press edge
   } btn_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;     // 20 ms
   localparam int DEFAULT_TIMEOUT_CYCLES  = 1500000000;  // 30 s

   localparam int NUM_BTNS  = 3;
   localparam int BTN_MODE  = 0;
   localparam int BTN_UP    = 1;
   localparam int BTN_DOWN  = 2;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [5:0] field_sel(input mode_state_t s);
      case (s)
         E_SEC:   field_sel = 6'b000001;
         E_MIN:   field_sel = 6'b000010;
         E_HOUR:  field_sel = 6'b000100;
         E_DAY:   field_sel = 6'b001000;
         E_MONTH: field_sel = 6'b010000;
         E_YEAR:  field_sel = 6'b100000;
         default: field_sel = 6'b000000;
      endcase
   endfunction

   function automatic mode_state_t next_mode(input mode_state_t s);
      case (s)
         RUN:     next_mode = E_SEC;
         E_SEC:   next_mode = E_MIN;
         E_MIN:   next_mode = E_HOUR;
         E_HOUR:  next_mode = E_DAY;
         E_DAY:   next_mode = E_MONTH;
         E_MONTH: next_mode = E_YEAR;
         default: next_mode = RUN;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton front end: 2-flop synchronizer, debouncer, press-edge pulse.
//   clk_50MHz : clock
//   rst_n     : async active-low reset
//   btn_n     : raw asynchronous active-low button
//   btn       : debounced level (1 = pressed) and one-cycle press pulse
module btn_debounce
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clk_50MHz,
   input  logic       rst_n,
   input  logic       btn_n,
   output btn_state_t btn
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [1:0]    vld_pipe;   // marks when sync_q[1] holds a real input sample
   logic          sample;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          level_d;
   logic          armed_q;

   assign sample = ~sync_q[1];

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= 2'b11;
         vld_pipe <= '0;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         level_d  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_n};
         vld_pipe <= {vld_pipe[0], 1'b1};
         level_d  <= level_q;
         // A button held through reset must be seen released before its
         // press can count; the reset-filled synchronizer does not qualify.
         if (vld_pipe[1] && !sample)
            armed_q <= 1'b1;
         if (sample == level_q)
            cnt_q <= '0;
         else if (cnt_q == CNT_LAST) begin
            level_q <= sample;
            cnt_q   <= '0;
         end else
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign btn.level = level_q;
   assign btn.press = armed_q & level_q & ~level_d;

endmodule

// File: rtl/set_mode_ctrl.sv
// Time-set mode controller: mode button walks RUN -> sec -> min -> hour ->
// day -> month -> year -> RUN; up/down request steps of the selected field;
// edit mode drops back to RUN after TIMEOUT_CYCLES without a press.
//   clk_50MHz              : clock
//   rst_n                  : async active-low reset
//   btn_mode_n/up_n/down_n : raw active-low pushbuttons
//   set_sec..set_year      : one-hot field select (registered)
//   inc, dec               : step request levels (registered)
//   editing                : any field selected
module set_mode_ctrl
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic btn_mode_n,
   input  logic btn_up_n,
   input  logic btn_down_n,
   output logic set_sec,
   output logic set_min,
   output logic set_hour,
   output logic set_day,
   output logic set_month,
   output logic set_year,
   output logic inc,
   output logic dec,
   output logic editing
);

   localparam int            IW        = cnt_width(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_SAT  = '1;

   logic [NUM_BTNS-1:0]             btn_n_vec;
   btn_state_t [NUM_BTNS-1:0]       btn;

   assign btn_n_vec = {btn_down_n, btn_up_n, btn_mode_n};

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
         .clk_50MHz (clk_50MHz),
         .rst_n     (rst_n),
         .btn_n     (btn_n_vec[g]),
         .btn       (btn[g])
      );
   end

   // The mode button only matters through its press pulse.
   logic unused_mode_level;
   assign unused_mode_level = btn[BTN_MODE].level;

   mode_state_t   state_q, state_nxt;
   logic [IW-1:0] idle_q, idle_nxt;
   logic [5:0]    sel_q;
   logic          inc_q, dec_q;
   logic          mode_press, any_press, timeout, step_ok;

   assign mode_press = btn[BTN_MODE].press;
   assign any_press  = btn[BTN_MODE].press | btn[BTN_UP].press | btn[BTN_DOWN].press;
   assign timeout    = (state_q != RUN) && (idle_q == IDLE_LAST);
   // No step in the cycle the selection changes, so a held up/down never
   // touches a freshly selected field early.
   assign step_ok    = (state_q != RUN) && (state_nxt == state_q);

   always_comb begin
      state_nxt = state_q;
      idle_nxt  = idle_q;
      // Mode press wins over a coincident timeout.
      if (mode_press)
         state_nxt = next_mode(state_q);
      else if (timeout)
         state_nxt = RUN;
      if (any_press || (state_nxt != state_q))
         idle_nxt = '0;
      else if ((state_q != RUN) && (idle_q != IDLE_SAT))
         idle_nxt = idle_q + 1'b1;
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         idle_q  <= '0;
         sel_q   <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         idle_q  <= idle_nxt;
         sel_q   <= field_sel(state_nxt);
         inc_q   <= step_ok & btn[BTN_UP].level & ~btn[BTN_DOWN].level;
         dec_q   <= step_ok & btn[BTN_DOWN].level & ~btn[BTN_UP].level;
      end
   end

   assign {set_year, set_month, set_day, set_hour, set_min, set_sec} = sel_q;
   assign inc     = inc_q;
   assign dec     = dec_q;
   assign editing = |sel_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Scoreboard bench for set_mode_ctrl: a queue/window reference model pushes
// the expected output vector every clock; a monitor pops and compares.
module tb_set_mode_ctrl;

   localparam int DB       = 4;
   localparam int TO       = 64;
   localparam int IDLE_SAT = (1 << $clog2(TO)) - 1;

   logic clk_50MHz = 1'b0;
   logic rst_n = 1'b0;
   logic btn_mode_n = 1'b1, btn_up_n = 1'b1, btn_down_n = 1'b1;
   logic set_sec, set_min, set_hour, set_day, set_month, set_year;
   logic inc, dec, editing;

   always #10 clk_50MHz = ~clk_50MHz;

   set_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .btn_mode_n(btn_mode_n),
      .btn_up_n  (btn_up_n),
      .btn_down_n(btn_down_n),
      .set_sec   (set_sec),
      .set_min   (set_min),
      .set_hour  (set_hour),
      .set_day   (set_day),
      .set_month (set_month),
      .set_year  (set_year),
      .inc       (inc),
      .dec       (dec),
      .editing   (editing)
   );

   // {set_year..set_sec, inc, dec, editing}
   typedef logic [8:0] obs_t;
   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic obs_t obs();
      return {set_year, set_month, set_day, set_hour, set_min, set_sec, inc, dec, editing};
   endfunction

   task automatic chk(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // hist: raw samples still in the synchronizer (2 = reset filler, released)
   // win : last DB synchronized samples seen by the debouncer
   int hist[3][$];
   bit win[3][$];
   bit m_level[3], m_armed[3], m_press[3];
   int m_idx, m_idle;

   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         hist[b].delete();
         hist[b].push_back(2);
         hist[b].push_back(2);
         win[b].delete();
         m_level[b] = 1'b0;
         m_armed[b] = 1'b0;
         m_press[b] = 1'b0;
      end
      m_idx  = 0;
      m_idle = 0;
   endtask

   initial model_reset();

   always @(posedge clk_50MHz) begin : model
      int       nidx, smp;
      bit       inc_e, dec_e, old, flip;
      bit [2:0] raw;
      obs_t     e;
      if (!rst_n) begin
         model_reset();
         exp_q.push_back('0);
      end else begin
         nidx = m_idx;
         if (m_press[0])
            nidx = (m_idx + 1) % 7;
         else if (m_idx != 0 && m_idle == TO - 1)
            nidx = 0;
         inc_e = (m_idx != 0) && (nidx == m_idx) && m_level[1] && !m_level[2];
         dec_e = (m_idx != 0) && (nidx == m_idx) && m_level[2] && !m_level[1];
         if (m_press[0] || m_press[1] || m_press[2] || nidx != m_idx)
            m_idle = 0;
         else if (m_idx != 0 && m_idle < IDLE_SAT)
            m_idle++;
         m_idx = nidx;

         raw = {~btn_down_n, ~btn_up_n, ~btn_mode_n};
         for (int b = 0; b < 3; b++) begin
            smp = hist[b].pop_front();
            hist[b].push_back(int'(raw[b]));
            if (smp == 0)
               m_armed[b] = 1'b1;
            win[b].push_back(smp == 1);
            if (win[b].size() > DB)
               void'(win[b].pop_front());
            old  = m_level[b];
            flip = (win[b].size() == DB);
            for (int i = 0; i < win[b].size(); i++)
               if (win[b][i] == old) flip = 1'b0;
            if (flip)
               m_level[b] = !old;
            m_press[b] = m_armed[b] && m_level[b] && !old;
         end

         e = '0;
         if (m_idx != 0) begin
            e[m_idx + 2] = 1'b1;
            e[0]         = 1'b1;
         end
         e[2] = inc_e;
         e[1] = dec_e;
         exp_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk_50MHz);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", obs(), e);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_50MHz);
   endtask

   task automatic set_btn(input int b, input bit pressed);
      case (b)
         0:       btn_mode_n = ~pressed;
         1:       btn_up_n   = ~pressed;
         default: btn_down_n = ~pressed;
      endcase
   endtask

   task automatic press(input int b, input int hold, input int nb);
      for (int i = 0; i < nb; i++) begin
         set_btn(b, (i % 2) == 0);
         tick(1);
      end
      set_btn(b, 1'b1);
      tick(hold);
      for (int i = 0; i < nb; i++) begin
         set_btn(b, (i % 2) != 0);
         tick(1);
      end
      set_btn(b, 1'b0);
   endtask

   task automatic mode_click(input int n);
      for (int i = 0; i < n; i++) begin
         press(0, 8, 0);
         tick(8);
      end
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      obs_t one_hot;
      int   r;
      bit   hit;
      tick(3);
      chk("reset_state", obs(), '0);
      rst_n = 1'b1;
      tick(4);

      // bouncing mode press -> exactly one advance
      press(0, 10, 3);
      tick(10);
      chk("bounce_one_advance", obs(), 9'b000001_00_1);

      // walk the remaining fields back to RUN, then a full lap of seven
      mode_click(6);
      chk("back_to_run", obs(), '0);
      for (int i = 1; i <= 7; i++) begin
         mode_click(1);
         one_hot = '0;
         if (i < 7) begin
            one_hot[i + 2] = 1'b1;
            one_hot[0]     = 1'b1;
         end
         chk("mode_walk", obs(), one_hot);
      end

      // up/down in E_MIN
      mode_click(2);
      set_btn(1, 1'b1);
      tick(12);
      chk("inc_in_min", obs(), 9'b000010_10_1);
      set_btn(2, 1'b1);
      tick(12);
      chk("up_down_both", obs(), 9'b000010_00_1);
      set_btn(1, 1'b0);
      tick(12);
      chk("dec_in_min", obs(), 9'b000010_01_1);
      set_btn(2, 1'b0);
      tick(10);
      mode_click(5);
      set_btn(1, 1'b1);
      tick(20);
      chk("no_inc_in_run", obs(), '0);
      set_btn(1, 1'b0);
      tick(10);

      // idle timeout from E_HOUR
      mode_click(3);
      chk("enter_hour", obs(), 9'b000100_00_1);
      tick(80);
      chk("timeout_to_run", obs(), '0);

      // mode press landing on the timeout cycle wins
      mode_click(3);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_idx == 3 && m_idle == TO - 1 - 6) hit = 1'b1;
         else tick(1);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL idle_wait t=%0t got=timeout exp=idle %0d", $time, TO - 7);
      end
      press(0, 10, 0);
      tick(10);
      chk("press_beats_timeout", obs(), 9'b001000_00_1);

      // reset with mode held mid-E_DAY
      set_btn(0, 1'b1);
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("reset_async", obs(), '0);
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("held_through_reset", obs(), '0);
      set_btn(0, 1'b0);
      tick(10);
      mode_click(1);
      chk("repress_after_reset", obs(), 9'b000001_00_1);

      // randomized traffic, scored by the model
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 7);
         case (r)
            0, 1: press(0, $urandom_range(6, 15), $urandom_range(0, 3));
            2:    press(1, $urandom_range(5, 25), $urandom_range(0, 3));
            3:    press(2, $urandom_range(5, 25), $urandom_range(0, 3));
            4: begin
               set_btn(1, 1'b1);
               tick($urandom_range(2, 10));
               set_btn(2, 1'b1);
               tick($urandom_range(2, 12));
               set_btn(1, 1'b0);
               tick($urandom_range(2, 10));
               set_btn(2, 1'b0);
            end
            5, 6: tick($urandom_range(40, 90));
            default: begin
               set_btn(0, $urandom_range(0, 1) == 1);
               rst_n = 1'b0;
               tick($urandom_range(1, 3));
               rst_n = 1'b1;
               tick($urandom_range(2, 12));
               set_btn(0, 1'b0);
            end
         endcase
         tick($urandom_range(6, 14));
      end

      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/set_mode_ctrl.md
SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of stable 50 MHz cycles (20 ms) before a debounced button level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 1500000000, SHALL set the number of cycles without a debounced press (30 s) after which edit mode exits.
REQ-003 clk_50MHz  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 btn_mode_n, btn_up_n, btn_down_n  input  1 each  SHALL be raw, asynchronous, active-low pushbuttons.
REQ-006 set_sec, set_min, set_hour, set_day, set_month, set_year  output  1 each  SHALL be field-select levels for the time counters, at most one high.
REQ-007 inc, dec  output  1 each  SHALL be step-request levels for the selected field.
REQ-008 editing  output  1  SHALL be high whenever any set_* is high.

Function
REQ-009 Each button SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-010 Debouncer: the level SHALL update only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from it; any differing sample SHALL restart the count.
REQ-011 The debounced mode press SHALL yield a 1-cycle press pulse on the debounced 0->1 (pressed) transition only.
REQ-012 FSM states: RUN, E_SEC, E_MIN, E_HOUR, E_DAY, E_MONTH, E_YEAR.
REQ-013 Each mode press pulse SHALL advance RUN->E_SEC->E_MIN->E_HOUR->E_DAY->E_MONTH->E_YEAR->RUN.
REQ-014 State E_x SHALL drive set_x high; RUN SHALL drive all set_* low; outputs SHALL be registered and change 1 cycle after the press pulse.
REQ-015 inc SHALL equal (debounced up pressed AND NOT debounced down pressed AND state != RUN), registered.
REQ-016 dec SHALL equal (debounced down pressed AND NOT debounced up pressed AND state != RUN), registered.
REQ-017 Simultaneous up and down SHALL drive inc=dec=0.
REQ-018 inc/dec SHALL be forced low in the same cycle set_* changes, so a held up/down never steps a newly selected field before the next cycle.
REQ-019 Idle counter: SHALL clear on any debounced press of any button or on any state change, increment while state != RUN, and saturate rather than wrap.
REQ-020 When the idle counter reaches TIMEOUT_CYCLES-1 with state != RUN, state SHALL become RUN on the next cycle.
REQ-021 A mode press pulse in the same cycle as the timeout SHALL take priority (normal advance).
REQ-022 Idle counter width SHALL be $clog2(TIMEOUT_CYCLES); debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES).

Reset
REQ-023 Reset SHALL force state RUN, all set_* 0, inc 0, dec 0, editing 0, synchronizers and debounced levels to released, and all counters 0.
REQ-024 Reset asserted mid-edit SHALL return to RUN immediately; a button held through reset release SHALL NOT generate a mode press pulse until it is released and pressed again.

Structure
REQ-025 Package clock_pkg SHALL hold the FSM state enumeration and the default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
REQ-026 Sub-module btn_debounce (synchronizer + debouncer, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.
REQ-027 No combinational path SHALL exist from any input to any output.

Verification (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-028 Mode button bouncing 3 toggles within 3 cycles, then held low 10 cycles -> exactly one advance RUN->E_SEC; set_sec=1, editing=1.
REQ-029 Seven clean mode presses -> set_sec, set_min, set_hour, set_day, set_month, set_year in turn, then all 0 (RUN).
REQ-030 In E_MIN, hold up 20 cycles -> inc=1 after debounce plus 3 cycles, dec=0; add down -> inc=dec=0; in RUN, hold up -> inc stays 0.
REQ-031 In E_HOUR, no buttons for 64 cycles -> state RUN, set_hour=0; a mode press at cycle 63 -> E_DAY instead.
REQ-032 Mode held, rst_n pulsed low mid-E_DAY -> all outputs 0 asynchronously; no advance until mode is released and re-pressed.
